// File: rtl/imem_boot_sequencer.sv
// Boot and run controller for the mini-MIPS core.
// Streams instruction words into imem through the core's loader port, holds
// the core in reset for a fixed number of cycles, then runs it, optionally
// stopping after a programmed cycle budget.
module imem_boot_sequencer #(
  parameter int ADDR_W       = 12,
  parameter int DEPTH        = 4096,
  parameter int CYC_W        = 32,
  parameter int RESET_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  input  logic [CYC_W-1:0]  run_cycles,
  output logic              cpu_reset,
  output logic              init_mode,
  output logic              write_enable,
  output logic [ADDR_W-1:0] init_address,
  output logic [31:0]       init_instruction,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [CYC_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST, S_RUN, S_STOP} state_t;

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RESET_CYCLES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         instr_q, instr_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [CYC_W-1:0]    cc_q, cc_d;
  logic [CYC_W-1:0]    budget_q, budget_d;
  logic [RC_W-1:0]     rc_q, rc_d;

  // State and datapath registers; reset restores every output to its idle value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      wl_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      instr_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      cc_q     <= '0;
      budget_q <= '0;
      rc_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wl_q     <= wl_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      done_q   <= done_d;
      error_q  <= error_d;
      cc_q     <= cc_d;
      budget_q <= budget_d;
      rc_q     <= rc_d;
    end
  end

  // Next-state logic: a new load may start from IDLE, RUN or STOP and takes
  // priority over budget expiry in RUN.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wl_d     = wl_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    instr_d  = instr_q;
    done_d   = done_q;
    error_d  = error_q;
    cc_d     = cc_q;
    budget_d = budget_q;
    rc_d     = rc_q;
    if (load_start && (state_q == S_IDLE || state_q == S_RUN || state_q == S_STOP)) begin
      state_d  = S_LOAD;
      ptr_d    = '0;
      wl_d     = '0;
      cc_d     = '0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      budget_d = run_cycles;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            instr_d = in_data;
            ptr_d   = ptr_q + 1'b1;
            wl_d    = wl_q + 1'b1;
            if (in_last) begin
              state_d = S_RST;
              rc_d    = '0;
            end else if (ptr_q == LAST_ADDR) begin
              error_d = 1'b1;
              state_d = S_STOP;
            end
          end
        end
        S_RST: begin
          if (rc_q == RC_LAST) state_d = S_RUN;
          else                 rc_d    = rc_q + 1'b1;
        end
        S_RUN: begin
          cc_d = cc_q + 1'b1;
          if (budget_q != '0 && cc_q == budget_q - 1'b1) begin
            state_d = S_STOP;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs; an overflowed load keeps the core in reset so it never runs.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    cpu_reset = 1'b1;
    init_mode = 1'b1;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_RST:  busy = 1'b1;
      S_RUN: begin
        busy      = 1'b1;
        cpu_reset = 1'b0;
        init_mode = 1'b0;
      end
      S_STOP: cpu_reset = error_q;
      default: ;
    endcase
  end

  assign write_enable     = we_q;
  assign init_address     = addr_q;
  assign init_instruction = instr_q;
  assign done             = done_q;
  assign error            = error_q;
  assign words_loaded     = wl_q;
  assign cycle_count      = cc_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Testbench for imem_boot_sequencer with an 8-word instruction memory.
module tb_imem_boot_sequencer;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int CYC_W  = 32;
  localparam int RSTC   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic [CYC_W-1:0]  run_cycles = '0;
  logic              cpu_reset, init_mode, write_enable, busy, done, error;
  logic [ADDR_W-1:0] init_address;
  logic [31:0]       init_instruction;
  logic [ADDR_W:0]   words_loaded;
  logic [CYC_W-1:0]  cycle_count;

  imem_boot_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CYC_W(CYC_W), .RESET_CYCLES(RSTC)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .run_cycles(run_cycles),
    .cpu_reset(cpu_reset), .init_mode(init_mode), .write_enable(write_enable),
    .init_address(init_address), .init_instruction(init_instruction), .busy(busy),
    .done(done), .error(error), .words_loaded(words_loaded), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int exp_n  = 0;   // words accepted so far in the current load (reference model)

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the next expected write.
  always @(negedge clk) begin
    if (write_enable) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(init_address), 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(init_address), 64'(e.addr));
        chk("wr_data", 64'(init_instruction), 64'(e.data));
        chk("wr_latency", 64'(cyc), 64'(e.cyc));
        chk("wr_init_mode", 64'(init_mode), 64'd1);
      end
    end
  end

  task automatic do_load_start(input logic [CYC_W-1:0] b);
    load_start = 1'b1;
    run_cycles = b;
    exp_n      = 0;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Offer one word and wait (bounded) for the handshake.
  task automatic send_word(input logic [31:0] d, input logic last);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) begin
      wr_t e;
      e.cyc  = cyc + 1;
      e.addr = 32'(exp_n);
      e.data = d;
      exp_q.push_back(e);
      exp_n++;
    end else begin
      chk("handshake_timeout", 64'd0, 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Watch reset hold, run length and the final STOP state of a budgeted run.
  task automatic run_check(input int budget, input int nwords);
    int  rst_n, run_n;
    bit  stopped;
    rst_n = 0; run_n = 0; stopped = 1'b0;
    for (int i = 0; i < budget + RSTC + 30; i++) begin
      @(negedge clk);
      if (!init_mode && !cpu_reset) run_n++;
      else if (busy && cpu_reset && !in_ready) rst_n++;
      else if (!busy) begin
        stopped = 1'b1;
        break;
      end
    end
    chk("run_stopped", 64'(stopped), 64'd1);
    chk("rst_cycles", 64'(rst_n), 64'(RSTC));
    chk("run_cycles", 64'(run_n), 64'(budget));
    chk("stop_done", 64'(done), 64'd1);
    chk("stop_cycle_count", 64'(cycle_count), 64'(budget));
    chk("stop_init_mode", 64'(init_mode), 64'd1);
    chk("stop_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("stop_words", 64'(words_loaded), 64'(nwords));
    chk("stop_error", 64'(error), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic load_and_run(input int n, input int budget, input int gap);
    do_load_start(CYC_W'(budget));
    for (int i = 0; i < n; i++) begin
      send_word($urandom, (i == n - 1));
      if (i != n - 1 && gap > 0) idle(gap);
    end
    run_check(budget, n);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    chk({tag, "_init_mode"}, 64'(init_mode), 64'd1);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_we"}, 64'(write_enable), 64'd0);
    chk({tag, "_addr"}, 64'(init_address), 64'd0);
    chk({tag, "_instr"}, 64'(init_instruction), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    chk({tag, "_cycles"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0003;
    prog[2] = 32'h0109_5020;

    // Reset state
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_values("reset");
    @(posedge clk); #1;

    // Directed three-word program, budget 5
    do_load_start(5);
    for (int i = 0; i < 3; i++) send_word(prog[i], (i == 2));
    run_check(5, 3);

    // in_valid toggling 1-0-1-0: addresses stay gap-free
    load_and_run(4, 3, 1);

    // Overflow of the 8-word memory without in_last
    do_load_start(5);
    for (int i = 0; i < DEPTH; i++) send_word($urandom, 1'b0);
    @(negedge clk);
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_busy", 64'(busy), 64'd0);
    chk("ovf_init_mode", 64'(init_mode), 64'd1);
    chk("ovf_words", 64'(words_loaded), 64'(DEPTH));
    chk("ovf_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_in_ready_9th", 64'(in_ready), 64'd0);
      chk("ovf_cpu_reset", 64'(cpu_reset), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Unlimited budget: 1000 run cycles, then abort with load_start
    do_load_start(0);
    send_word(32'h1234_5678, 1'b1);
    begin
      int run_n;
      run_n = 0;
      for (int i = 0; i < 1100 && run_n < 1000; i++) begin
        @(negedge clk);
        if (!init_mode && !cpu_reset) run_n++;
      end
      chk("unl_run_reached", 64'(run_n), 64'd1000);
    end
    @(negedge clk);
    chk("unl_busy", 64'(busy), 64'd1);
    chk("unl_done", 64'(done), 64'd0);
    chk("unl_cycle_count", 64'(cycle_count), 64'd1000);
    @(posedge clk); #1;
    do_load_start(3);
    @(negedge clk);
    chk("abort_in_load", 64'(in_ready), 64'd1);
    chk("abort_cycle_count", 64'(cycle_count), 64'd0);
    chk("abort_cpu_reset", 64'(cpu_reset), 64'd1);
    @(posedge clk); #1;
    send_word($urandom, 1'b1);
    run_check(3, 1);

    // load_start on the same cycle the budget of 4 expires
    do_load_start(4);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!init_mode && cycle_count == 32'd3) begin
          load_start = 1'b1;
          run_cycles = 7;
          exp_n      = 0;
          @(posedge clk); #1;
          load_start = 1'b0;
          hit = 1'b1;
          break;
        end
      end
      chk("expiry_reached", 64'(hit), 64'd1);
    end
    @(negedge clk);
    chk("expiry_in_load", 64'(in_ready), 64'd1);
    chk("expiry_done", 64'(done), 64'd0);
    chk("expiry_cycle_count", 64'(cycle_count), 64'd0);
    @(posedge clk); #1;

    // Reset in the cycle after a handshake drops the next in-flight word
    send_word(32'hAAAA_0001, 1'b0);
    send_word(32'hAAAA_0002, 1'b0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hBBBB_BBBB;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_reset_values("midload_reset");
    @(posedge clk); #1;

    // Randomized programs
    for (int t = 0; t < 6; t++) begin
      load_and_run($urandom_range(1, DEPTH - 1), $urandom_range(1, 9), $urandom_range(0, 2));
    end

    idle(3);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
